// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path.
//   - tx_state_e : frame FSM states (STOP2 is only reachable when the
//                  design is built with UART_TX_TWO_STOP_EN defined)
//   - START_BIT / STOP_BIT : line levels of the framing bits
//   - cnt_width() : width of the data-bit counter for a given payload size
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    STOP2  = 3'd5
  } tx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Counter only has to reach DATA_WIDTH-1, never DATA_WIDTH.
  function automatic int cnt_width(input int data_width);
    return (data_width < 2) ? 1 : $clog2(data_width);
  endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Handshake/line bundle of the UART transmit frame controller.
//   p_data, data_valid, par_en : byte request from the host side
//   parity_bit                 : parity from the external parity_calc block
//   tx_out, busy, ser_done     : registered controller outputs
// Modports: master = requester / parity source, slave = uart_tx_ctrl.
interface uart_tx_ctrl_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_en;
  logic                  parity_bit;
  logic                  tx_out;
  logic                  busy;
  logic                  ser_done;

  modport master (
    output p_data, data_valid, par_en, parity_bit,
    input  tx_out, busy, ser_done
  );

  modport slave (
    input  p_data, data_valid, par_en, parity_bit,
    output tx_out, busy, ser_done
  );

endinterface

// File: rtl/uart_tx_serializer.sv
// Data shift register and bit counter of the UART transmitter.
//   clk, rst_n  : bit clock, synchronous active-low reset
//   load        : capture load_data and clear the counter
//   load_data   : payload to serialise
//   shift_en    : shift right one bit and advance the counter
//   serial_bit  : current LSB of the shift register
//   last_bit    : counter is on the final data bit
//   ser_done    : registered pulse during the last data-bit cycle
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  shift_en,
  output logic                  serial_bit,
  output logic                  last_bit,
  output logic                  ser_done
);

  localparam int             CW       = cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0]  LAST_IDX = CW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ser_done_q, ser_done_d;

  assign last_bit   = (cnt_q == LAST_IDX);
  assign serial_bit = shift_q[0];
  assign ser_done   = ser_done_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    ser_done_d = 1'b0;
    if (load) begin
      shift_d = load_data;
      cnt_d   = '0;
    end else if (shift_en) begin
      shift_d    = shift_q >> 1;
      // Hold on the last bit so the counter never wraps inside a frame.
      cnt_d      = last_bit ? cnt_q : cnt_q + CW'(1);
      ser_done_d = last_bit;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      // NOTE: the shift register is reset too, so an aborted frame leaves no stale payload.
      shift_q    <= '0;
      cnt_q      <= '0;
      ser_done_q <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      ser_done_q <= ser_done_d;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: frame FSM and registered line mux.
// Frame: start bit, DATA_WIDTH data bits LSB first, optional parity, stop.
//   clk, rst_n : bit clock (one cycle per bit), synchronous active-low reset
//   bus        : uart_tx_ctrl_if.slave
//                in : p_data, data_valid, par_en, parity_bit
//                out: tx_out (idle high), busy, ser_done (all registered)
// Build option: UART_TX_TWO_STOP_EN adds a second stop bit (STOP2).
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_ctrl_if.slave  bus
);

  tx_state_e state_q, state_d;
  logic      tx_out_q, tx_out_d;
  logic      busy_q, busy_d;
  logic      par_en_q, par_en_d;
  logic      load, shift_en, serial_bit, last_bit, ser_done;

  uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_serializer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_data  (bus.p_data),
    .shift_en   (shift_en),
    .serial_bit (serial_bit),
    .last_bit   (last_bit),
    .ser_done   (ser_done)
  );

  // Outputs are registered from the current state, so the line lags the
  // state by one edge: accept at N puts START on the line from edge N+1.
  always_comb begin
    state_d  = state_q;
    tx_out_d = STOP_BIT;
    busy_d   = 1'b1;
    par_en_d = par_en_q;
    load     = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.data_valid) begin
          load     = 1'b1;
          par_en_d = bus.par_en;
          state_d  = START;
        end
      end
      START: begin
        tx_out_d = START_BIT;
        state_d  = DATA;
      end
      DATA: begin
        tx_out_d = serial_bit;
        shift_en = 1'b1;
        if (last_bit) state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        tx_out_d = bus.parity_bit;
        state_d  = STOP;
      end
      STOP: begin
`ifdef UART_TX_TWO_STOP_EN
        state_d = STOP2;
`else
        state_d = IDLE;
`endif
      end
`ifdef UART_TX_TWO_STOP_EN
      STOP2: state_d = IDLE;
`endif
      default: begin
        // Unused encodings drop straight back to an idle line.
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tx_out_q <= STOP_BIT;
      busy_q   <= 1'b0;
      par_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_out_q <= tx_out_d;
      busy_q   <= busy_d;
      par_en_q <= par_en_d;
    end
  end

  assign bus.tx_out   = tx_out_q;
  assign bus.busy     = busy_q;
  assign bus.ser_done = ser_done;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: a table of per-cycle vectors for
// reset/idle and two frames, plus hand-written back-to-back and mid-frame
// reset sequences. Honours UART_TX_TWO_STOP_EN like the design.
module tb_uart_tx_ctrl;

  localparam int DW = 8;
`ifdef UART_TX_TWO_STOP_EN
  localparam int N_STOP = 2;
`else
  localparam int N_STOP = 1;
`endif

  typedef struct {
    logic          dv;
    logic [DW-1:0] d;
    logic          pe;
    logic          pb;
    logic          rst;
    logic [2:0]    exp;   // {tx_out, busy, ser_done} after the edge
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[$];

  uart_tx_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [2:0] outs();
    return {bus.tx_out, bus.busy, bus.ser_done};
  endfunction

  function automatic void add(input logic dv, input logic [DW-1:0] d, input logic pe,
                              input logic pb, input logic rst, input logic [2:0] exp);
    vec_t v;
    v.dv = dv; v.d = d; v.pe = pe; v.pb = pb; v.rst = rst; v.exp = exp;
    vecs.push_back(v);
  endfunction

  // Called #1 after the accept edge. Checks every frame cycle, then one
  // more edge where busy must be low. p_data is changed to mid_d during
  // the frame to show the latched copy is used.
  task automatic run_frame(input string tag, input logic [DW-1:0] d, input logic pe,
                           input logic [DW-1:0] mid_d);
    int   n;
    logic exp_tx;
    n = 1 + DW + (pe ? 1 : 0) + N_STOP;
    bus.parity_bit = ^d;  // even parity, as parity_calc would produce
    for (int i = 0; i < n; i++) begin
      step();
      if (i == 0) bus.p_data = mid_d;
      if (i == 0)                    exp_tx = 1'b0;
      else if (i <= DW)              exp_tx = d[i-1];
      else if (pe && i == DW + 1)    exp_tx = ^d;
      else                           exp_tx = 1'b1;
      check($sformatf("%s_c%0d", tag, i + 1), {5'd0, outs()},
            {5'd0, exp_tx, 1'b1, (i == DW)});
    end
    step();
    check($sformatf("%s_end", tag), {5'd0, outs()}, 8'b0000_0100);
  endtask

  initial begin
    // Reset 3 cycles, then 5 idle cycles.
    for (int i = 0; i < 3; i++) add(0, 8'h00, 0, 0, 0, 3'b100);
    for (int i = 0; i < 5; i++) add(0, 8'h00, 0, 0, 1, 3'b100);
    // 0xA5 with parity (even parity 0); p_data/par_en change after accept.
    add(1, 8'hA5, 1, 0, 1, 3'b100);
    add(0, 8'h00, 0, 0, 1, 3'b010);  // start
    add(0, 8'h00, 0, 0, 1, 3'b110);  // d0=1
    add(0, 8'h00, 0, 0, 1, 3'b010);  // d1=0
    add(0, 8'h00, 0, 0, 1, 3'b110);  // d2=1
    add(0, 8'h00, 0, 0, 1, 3'b010);  // d3=0
    add(0, 8'h00, 0, 0, 1, 3'b010);  // d4=0
    add(0, 8'h00, 0, 0, 1, 3'b110);  // d5=1
    add(0, 8'h00, 0, 0, 1, 3'b010);  // d6=0
    add(0, 8'h00, 0, 0, 1, 3'b111);  // d7=1, ser_done
    add(0, 8'h00, 0, 0, 1, 3'b010);  // parity 0
    add(0, 8'h00, 0, 0, 1, 3'b110);  // stop
`ifdef UART_TX_TWO_STOP_EN
    add(0, 8'h00, 0, 0, 1, 3'b110);  // second stop
`endif
    add(0, 8'h00, 0, 0, 1, 3'b100);  // idle, busy low
    // 0x07 without parity; par_en raised mid-frame must not add a parity slot.
    add(1, 8'h07, 0, 1, 1, 3'b100);
    add(0, 8'hFF, 1, 1, 1, 3'b010);  // start
    add(0, 8'hFF, 1, 1, 1, 3'b110);
    add(0, 8'hFF, 1, 1, 1, 3'b110);
    add(0, 8'hFF, 1, 1, 1, 3'b110);
    add(0, 8'hFF, 1, 1, 1, 3'b010);
    add(0, 8'hFF, 1, 1, 1, 3'b010);
    add(0, 8'hFF, 1, 1, 1, 3'b010);
    add(0, 8'hFF, 1, 1, 1, 3'b010);
    add(0, 8'hFF, 1, 1, 1, 3'b011);  // d7=0, ser_done
    add(0, 8'hFF, 1, 1, 1, 3'b110);  // stop
`ifdef UART_TX_TWO_STOP_EN
    add(0, 8'hFF, 1, 1, 1, 3'b110);
`endif
    add(0, 8'hFF, 1, 1, 1, 3'b100);
    add(0, 8'hFF, 1, 1, 1, 3'b100);

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n          = vecs[i].rst;
      bus.data_valid = vecs[i].dv;
      bus.p_data     = vecs[i].d;
      bus.par_en     = vecs[i].pe;
      bus.parity_bit = vecs[i].pb;
      step();
      check($sformatf("vec%0d", i), {5'd0, outs()}, {5'd0, vecs[i].exp});
    end

    // Back-to-back: data_valid held high, 0x01 then 0x80, both with parity.
    bus.par_en     = 1'b1;
    bus.p_data     = 8'h01;
    bus.data_valid = 1'b1;
    step();
    check("b2b_accept", {5'd0, outs()}, 8'b0000_0100);
    run_frame("b2b_f1", 8'h01, 1'b1, 8'h80);  // last edge here accepts frame 2
    bus.data_valid = 1'b0;
    run_frame("b2b_f2", 8'h80, 1'b1, 8'h55);

    // Reset during data bit 4 of 0xFF, then a clean 0x3C frame.
    bus.par_en     = 1'b0;
    bus.p_data     = 8'hFF;
    bus.data_valid = 1'b1;
    step();
    bus.data_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("rst_bit4", {5'd0, outs()}, 8'b0000_0110);
    rst_n = 1'b0;
    step();
    check("rst_abort", {5'd0, outs()}, 8'b0000_0100);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst_idle%0d", i), {5'd0, outs()}, 8'b0000_0100);
    end
    bus.par_en     = 1'b1;
    bus.p_data     = 8'h3C;
    bus.data_valid = 1'b1;
    step();
    bus.data_valid = 1'b0;
    check("post_rst_accept", {5'd0, outs()}, 8'b0000_0100);
    run_frame("post_rst", 8'h3C, 1'b1, 8'hC3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
